// File: rtl/tt_sweep_capture.sv
// Sweep harness around a 7-input combinational function: walks x through all 128 patterns,
// captures fn_out into a 128-bit truth table with its onset count, and hands it off via valid/ready.
module tt_sweep_capture #(
  parameter int unsigned LAT   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic [6:0]       o_x,
  input  logic             i_fn_out,
  output logic             o_busy,
  output logic [127:0]     o_tt,
  output logic [CNT_W-1:0] o_ones,
  output logic             o_tt_valid,
  input  logic             i_tt_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

  localparam logic [2:0] DrainLast = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_e           r_state;
  logic [6:0]       r_x;
  logic [6:0]       r_cap_idx;
  logic [2:0]       r_drain;
  logic [127:0]     r_tt;
  logic [CNT_W-1:0] r_ones;
  logic             r_busy;
  logic             r_tt_valid;

  logic w_start_acc;
  logic w_launch;
  logic w_cap_en;

  assign w_start_acc = (r_state == StIdle) && i_start;
  // Every SWEEP cycle presents exactly one pattern on x.
  assign w_launch    = (r_state == StSweep);

  // Capture-enable line: a launch reaches the capture point LAT cycles later.
  if (LAT == 0) begin : g_no_line
    assign w_cap_en = w_launch;
  end else begin : g_line
    logic [LAT-1:0] r_cap_line;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cap_line <= '0;
      end else if (w_start_acc) begin
        r_cap_line <= '0;
      end else begin
        r_cap_line[0] <= w_launch;
        for (int i = 1; i < int'(LAT); i++) begin
          r_cap_line[i] <= r_cap_line[i-1];
        end
      end
    end

    assign w_cap_en = r_cap_line[LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_cap_idx  <= '0;
      r_drain    <= '0;
      r_tt       <= '0;
      r_ones     <= '0;
      r_busy     <= 1'b0;
      r_tt_valid <= 1'b0;
    end else begin
      // Capture runs off the delayed launch line, independent of where x currently is.
      if (w_cap_en) begin
        r_tt[r_cap_idx] <= i_fn_out;
        r_ones          <= r_ones + CNT_W'(i_fn_out);
        r_cap_idx       <= r_cap_idx + 7'd1;
      end

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state   <= StSweep;
            r_x       <= '0;
            r_cap_idx <= '0;
            r_drain   <= '0;
            r_tt      <= '0;
            r_ones    <= '0;
            r_busy    <= 1'b1;
          end
        end

        StSweep: begin
          if (r_x == 7'd127) begin
            if (LAT == 0) begin
              r_state    <= StDone;
              r_busy     <= 1'b0;
              r_tt_valid <= 1'b1;
            end else begin
              r_state <= StDrain;
              r_drain <= '0;
            end
          end else begin
            r_x <= r_x + 7'd1;
          end
        end

        StDrain: begin
          if (r_drain == DrainLast) begin
            r_state    <= StDone;
            r_busy     <= 1'b0;
            r_tt_valid <= 1'b1;
          end else begin
            r_drain <= r_drain + 3'd1;
          end
        end

        StDone: begin
          if (i_tt_ready) begin
            r_state    <= StIdle;
            r_tt_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_x        = r_x;
  assign o_busy     = r_busy;
  assign o_tt       = r_tt;
  assign o_ones     = r_ones;
  assign o_tt_valid = r_tt_valid;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: one LAT=0 and one LAT=3 instance swept together against
// lookup-table functions, with expected tables and onset counts taken from the tables.
module tb_tt_sweep_capture;

  logic clk;
  logic rst_n;
  logic start;
  logic ready;

  logic [127:0] tbl0;
  logic [127:0] tbl3;
  logic [127:0] maj_tt;

  logic [6:0]   w_x0, w_x3;
  logic         w_fn0, w_fn3;
  logic         w_busy0, w_busy3;
  logic [127:0] w_tt0, w_tt3;
  logic [7:0]   w_ones0, w_ones3;
  logic         w_valid0, w_valid3;
  logic         r_d1, r_d2, r_d3;

  int n_cmp;
  int n_fail;

  tt_sweep_capture #(.LAT(0), .CNT_W(8)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .o_x       (w_x0),
    .i_fn_out  (w_fn0),
    .o_busy    (w_busy0),
    .o_tt      (w_tt0),
    .o_ones    (w_ones0),
    .o_tt_valid(w_valid0),
    .i_tt_ready(ready)
  );

  tt_sweep_capture #(.LAT(3), .CNT_W(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .o_x       (w_x3),
    .i_fn_out  (w_fn3),
    .o_busy    (w_busy3),
    .o_tt      (w_tt3),
    .o_ones    (w_ones3),
    .o_tt_valid(w_valid3),
    .i_tt_ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test: table lookup, direct for LAT=0, three register stages for LAT=3.
  assign w_fn0 = tbl0[w_x0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
      r_d3 <= 1'b0;
    end else begin
      r_d1 <= tbl3[w_x3];
      r_d2 <= r_d1;
      r_d3 <= r_d2;
    end
  end
  assign w_fn3 = r_d3;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x0"}, 128'(w_x0), 128'd0);
    check({tag, "_x3"}, 128'(w_x3), 128'd0);
    check({tag, "_tt0"}, w_tt0, 128'd0);
    check({tag, "_tt3"}, w_tt3, 128'd0);
    check({tag, "_ones0"}, 128'(w_ones0), 128'd0);
    check({tag, "_ones3"}, 128'(w_ones3), 128'd0);
    check({tag, "_busy"}, 128'({w_busy0, w_busy3}), 128'd0);
    check({tag, "_valid"}, 128'({w_valid0, w_valid3}), 128'd0);
  endtask

  // Full sweep on both instances; expects to be called 1 time unit after a rising edge.
  task automatic run_sweep(input string tag, input int hold, input bit poke);
    int lat0, lat3, n;
    logic b0, b3;
    lat0 = -1;
    lat3 = -1;
    b0   = 1'b1;
    b3   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, 128'({w_busy0, w_busy3}), 128'b11);
    n = 0;
    while ((lat0 < 0 || lat3 < 0) && n < 300) begin
      start = poke && (n == 40);
      @(posedge clk); #1;
      n++;
      if (lat0 < 0 && w_valid0) begin lat0 = n; b0 = w_busy0; end
      if (lat3 < 0 && w_valid3) begin lat3 = n; b3 = w_busy3; end
    end
    start = 1'b0;
    check({tag, "_lat0"}, 128'(lat0), 128'd128);
    check({tag, "_lat3"}, 128'(lat3), 128'd131);
    check({tag, "_busy0_at_valid"}, 128'(b0), 128'd0);
    check({tag, "_busy3_at_valid"}, 128'(b3), 128'd0);
    check({tag, "_tt0"}, w_tt0, tbl0);
    check({tag, "_ones0"}, 128'(w_ones0), 128'($countones(tbl0)));
    check({tag, "_tt3"}, w_tt3, tbl3);
    check({tag, "_ones3"}, 128'(w_ones3), 128'($countones(tbl3)));
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == hold / 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (hold > 0) begin
      check({tag, "_hold_valid"}, 128'({w_valid0, w_valid3}), 128'b11);
      check({tag, "_hold_tt0"}, w_tt0, tbl0);
      check({tag, "_hold_tt3"}, w_tt3, tbl3);
      check({tag, "_hold_ones3"}, 128'(w_ones3), 128'($countones(tbl3)));
    end
    ready = 1'b1;
    start = poke;
    @(posedge clk); #1;
    ready = 1'b0;
    start = 1'b0;
    check({tag, "_valid_drop"}, 128'({w_valid0, w_valid3}), 128'd0);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, 128'({w_busy0, w_busy3}), 128'd0);
    check({tag, "_idle_x0"}, 128'(w_x0), 128'd127);
    check({tag, "_idle_tt0"}, w_tt0, tbl0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    start  = 1'b0;
    ready  = 1'b0;
    rst_n  = 1'b0;
    tbl0   = '0;
    tbl3   = '0;
    maj_tt = 128'hfee8e8e8eae8e8c8ece8e8a8e8e8e880;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl0 = '0;
    tbl3 = {4{32'haaaaaaaa}};
    run_sweep("zero_alt", 0, 1'b0);

    tbl0 = '1;
    tbl3 = '1;
    run_sweep("ones", 0, 1'b0);

    tbl0 = maj_tt;
    tbl3 = maj_tt;
    run_sweep("maj", 0, 1'b0);

    tbl0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    tbl3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_sweep("stall", 50, 1'b1);

    // Abort a sweep at cycle 60 and confirm the next one carries no residue.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tbl0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    tbl3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_sweep("post_rst", 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential harness stage around a 7-input single-output combinational function block (majority-gate network, ports x0..x6 -> out).
- Upstream, it drives the function's inputs through all 128 patterns.
- Downstream, it captures the function output for each pattern, assembles the 128-bit truth table and counts its ones (onset size).
- Hands the result to the classification logic over a valid/ready interface.

Parameters:
- LAT, 0, pipeline latency in cycles of the function under test, measured from the registered x outputs to fn_out; legal range 0..7.
- CNT_W, 8, width of the onset-size count; must hold 128.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- x  out  7  pattern to the function under test, registered; x[0] drives x0 ... x[6] drives x6.
- fn_out  in  1  function output (out of the function block).
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- tt  out  128  truth table; bit i = fn_out for pattern index i, with x = i (x0 = LSB).
- ones  out  CNT_W  number of set bits in tt.
- tt_valid  out  1  result valid; high in DONE.
- tt_ready  in  1  consumer accepts the result when tt_valid & tt_ready.

Behaviour:
- Reset (async assert, sync release): state = IDLE; x = 0, tt = 0, ones = 0, busy = 0, tt_valid = 0; internal pattern and capture counters = 0.
- Reset mid-sweep or mid-DONE aborts immediately. The partial result is discarded and nothing is emitted.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE -> SWEEP on start = 1.
  - On that edge: x <= 0, tt <= 0, ones <= 0, busy <= 1.
  - The launch counter and capture counter are both cleared.
- SWEEP:
  - Each cycle x <= x + 1. Pattern k is presented on x during SWEEP cycle k (k = 0..127).
  - After x = 127 has been presented for one cycle: move to DRAIN if LAT > 0, else go straight to DONE.
  - x holds 127 after the sweep and returns to 0 only on the next start.
- Capture:
  - A capture-enable shift line of depth LAT tracks launched patterns.
  - fn_out for pattern k is sampled on the edge ending cycle k + LAT.
  - On that edge: tt[k] <= fn_out, and ones <= ones + fn_out.
  - The capture index increments independently of x.
  - Capture never writes a bit twice; exactly 128 captures occur per sweep.
- DRAIN: stays exactly LAT cycles to collect the in-flight results, then -> DONE.
- DONE:
  - busy = 0, tt_valid = 1; tt and ones are stable.
  - On tt_valid & tt_ready -> IDLE; tt_valid drops on the next cycle.
  - tt and ones keep their values until the next accepted start.
- Sweep length: start accepted at edge E -> tt_valid first high after edge E + 128 + LAT.
- start handling:
  - start in SWEEP, DRAIN or DONE is ignored. There is no queueing and no restart.
  - start in the same cycle as the DONE handshake is ignored; IDLE must be reached first.
- tt_ready may be held low indefinitely; the result holds with no loss.
- Arithmetic: ones never exceeds 128, so it needs no saturation. A constant-1 function yields exactly 128.
- The block does not check fn_out for X; the bench does.

Test Plan:
- LAT = 0, fn_out tied 0, start pulse -> tt_valid high after 128 cycles; tt = 0, ones = 0.
- LAT = 0, fn_out tied 1 -> tt = all ones, ones = 128; busy low in the same cycle tt_valid rises.
- LAT = 3, fn_out = x[0] passed through a 3-stage delay -> tt = 0xAAAA...AAAA, ones = 64; tt_valid at start + 131 cycles.
- LAT = 0, the majority-gate network (w0..w5) as the function under test -> tt = 0xfee8e8e8eae8e8c8ece8e8a8e8e8e880, ones = 64.
- Hold tt_ready = 0 for 50 cycles in DONE, pulse start during SWEEP and during DONE -> result stable throughout; a single handshake; no second sweep until start is given in IDLE.
- Assert rst_n = 0 at sweep cycle 60, release, then start -> outputs are at reset values during reset; the fresh sweep yields the correct full tt with no residue from the aborted run.
